branch_resolve: RTL and testbench

- Ex-stage end of the branch-prediction loop. Takes each resolved control-flow instruction with the prediction it carried from fetch, and computes the real next PC and whether the prediction was wrong.
- Drives the predictor's feedback bus (exVld/exPC/exPCTar/exType/exBranch/exWrong) and the front-end redirect.
- Drops wrong-path results for a fixed shadow after a mispredict and keeps prediction-accuracy counters.

---
 rtl/branch_resolve_pkg.sv | 22 ++
 rtl/branch_resolve_sat.sv | 18 +
 rtl/branch_resolve.sv | 115 +++++++++++
 tb/tb_branch_resolve.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared types for the ex-stage branch resolver: branch-type encodings,
// resolver state encoding and the PC hash sent to the predictor.
package branch_resolve_pkg;

    typedef enum logic [1:0] {
        BR_NONE     = 2'b00,
        BR_COND     = 2'b01,
        BR_DIRECT   = 2'b10,
        BR_INDIRECT = 2'b11
    } br_type_e;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Drops the word-offset bits; callers truncate to their hash width.
    function automatic logic [63:0] pc_hash(input logic [63:0] pc);
        return pc >> 2;
    endfunction

endpackage

// File: rtl/branch_resolve_sat.sv
// Saturating up-counter used for prediction-accuracy statistics.
module sat_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (inc && !(&count))
            count <= count + CNT_WIDTH'(1);
    end

endmodule

// File: rtl/branch_resolve.sv
// Resolves ex-stage control flow against the fetch prediction, feeds the
// predictor, redirects the front end and masks the wrong-path shadow.
module branch_resolve
    import branch_resolve_pkg::*;
#(
    parameter int ADDR_WIDTH   = 32,
    parameter int HASH_WIDTH   = 24,
    parameter int FLUSH_CYCLES = 3,
    parameter int CNT_WIDTH    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  brVld,
    input  logic [ADDR_WIDTH-1:0] brPC,
    input  logic [1:0]            brType,
    input  logic                  brCond,
    input  logic [ADDR_WIDTH-1:0] brTarget,
    input  logic                  pdBranch,
    input  logic [ADDR_WIDTH-1:0] pdPC,
    input  logic                  extFlush,
    output logic                  exVld,
    output logic [HASH_WIDTH-1:0] exPC,
    output logic [HASH_WIDTH-1:0] exPCTar,
    output logic [1:0]            exType,
    output logic                  exBranch,
    output logic                  exWrong,
    output logic                  redirVld,
    output logic [ADDR_WIDTH-1:0] redirPC,
    output logic                  inShadow,
    output logic [CNT_WIDTH-1:0]  brCount,
    output logic [CNT_WIDTH-1:0]  missCount
);

    localparam int SW = $clog2(FLUSH_CYCLES + 1);

    state_e                state;
    logic [SW-1:0]         shadow_cnt;
    logic                  taken;
    logic [ADDR_WIDTH-1:0] actual_next;
    logic                  wrong;
    logic                  accept;

    always_comb begin
        taken = 1'b0;
        case (brType)
            BR_COND:     taken = brCond;
            BR_DIRECT:   taken = 1'b1;
            BR_INDIRECT: taken = 1'b1;
            default:     taken = 1'b0;
        endcase
    end

    // Target is compared for every type so stale predictor entries on
    // non-branches show up as mispredicts.
    assign actual_next = taken ? brTarget : brPC + ADDR_WIDTH'(4);
    assign wrong       = (pdBranch != taken) || (actual_next != pdPC);
    assign accept      = brVld && (state == ST_RUN) && !extFlush;
    assign inShadow    = (state == ST_FLUSH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_RUN;
            shadow_cnt <= '0;
            exVld      <= 1'b0;
            exPC       <= '0;
            exPCTar    <= '0;
            exType     <= '0;
            exBranch   <= 1'b0;
            exWrong    <= 1'b0;
            redirVld   <= 1'b0;
            redirPC    <= '0;
        end else begin
            exVld    <= accept;
            redirVld <= accept && wrong;
            if (accept) begin
                exPC     <= HASH_WIDTH'(pc_hash(64'(brPC)));
                exPCTar  <= HASH_WIDTH'(pc_hash(64'(brTarget)));
                exType   <= brType;
                exBranch <= taken;
                exWrong  <= wrong;
            end
            if (accept && wrong)
                redirPC <= actual_next;

            if (extFlush) begin
                state      <= ST_RUN;
                shadow_cnt <= '0;
            end else if (accept && wrong) begin
                state      <= ST_FLUSH;
                shadow_cnt <= SW'(FLUSH_CYCLES);
            end else if (state == ST_FLUSH) begin
                // Leave on the decrement that reaches zero so the next
                // input lands FLUSH_CYCLES+1 cycles after the mispredict.
                shadow_cnt <= shadow_cnt - SW'(1);
                if (shadow_cnt == SW'(1))
                    state <= ST_RUN;
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && (brType != BR_NONE)),
        .count (brCount)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (accept && wrong),
        .count (missCount)
    );

endmodule

// File: tb/tb_branch_resolve.sv
// Directed bench for branch_resolve with a cycle-indexed reference model;
// narrow counters make saturation reachable.
module tb_branch_resolve;

    localparam int AW = 32;
    localparam int HW = 24;
    localparam int FC = 3;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          brVld = 1'b0;
    logic [AW-1:0] brPC = '0;
    logic [1:0]    brType = '0;
    logic          brCond = 1'b0;
    logic [AW-1:0] brTarget = '0;
    logic          pdBranch = 1'b0;
    logic [AW-1:0] pdPC = '0;
    logic          extFlush = 1'b0;
    logic          exVld;
    logic [HW-1:0] exPC;
    logic [HW-1:0] exPCTar;
    logic [1:0]    exType;
    logic          exBranch;
    logic          exWrong;
    logic          redirVld;
    logic [AW-1:0] redirPC;
    logic          inShadow;
    logic [CW-1:0] brCount;
    logic [CW-1:0] missCount;

    int n_checks = 0;
    int n_err    = 0;

    branch_resolve #(.ADDR_WIDTH(AW), .HASH_WIDTH(HW), .FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .brVld(brVld), .brPC(brPC), .brType(brType),
        .brCond(brCond), .brTarget(brTarget), .pdBranch(pdBranch), .pdPC(pdPC),
        .extFlush(extFlush), .exVld(exVld), .exPC(exPC), .exPCTar(exPCTar),
        .exType(exType), .exBranch(exBranch), .exWrong(exWrong),
        .redirVld(redirVld), .redirPC(redirPC), .inShadow(inShadow),
        .brCount(brCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: shadow tracked as the first cycle index that may accept again.
    int            cyc = 0;
    int            resume = 0;
    logic          e_vld, e_redir, e_shadow, e_branch, e_wrong;
    logic [AW-1:0] e_redirpc;
    logic [HW-1:0] e_pc, e_tar;
    logic [1:0]    e_type;
    logic [CW-1:0] e_br, e_miss;

    always @(posedge clk or posedge rst) begin
        logic          tk, wr, acc;
        logic [AW-1:0] nx;
        if (rst) begin
            e_vld <= 0; e_redir <= 0; e_shadow <= 0; e_branch <= 0; e_wrong <= 0;
            e_redirpc <= '0; e_pc <= '0; e_tar <= '0; e_type <= '0;
            e_br <= '0; e_miss <= '0; resume <= 0;
        end else begin
            tk  = (brType == 2'b01) ? brCond : (brType != 2'b00);
            nx  = tk ? brTarget : brPC + 32'd4;
            wr  = (pdBranch != tk) || (nx != pdPC);
            acc = brVld && !extFlush && (cyc >= resume);
            e_vld   <= acc;
            e_redir <= acc && wr;
            if (acc && wr) e_redirpc <= nx;
            if (acc) begin
                e_pc <= HW'(brPC >> 2); e_tar <= HW'(brTarget >> 2);
                e_type <= brType; e_branch <= tk; e_wrong <= wr;
            end
            if (acc && brType != 2'b00 && e_br != {CW{1'b1}}) e_br <= e_br + 1'b1;
            if (acc && wr && e_miss != {CW{1'b1}}) e_miss <= e_miss + 1'b1;
            if (extFlush) begin
                resume <= cyc + 1; e_shadow <= 0;
            end else if (acc && wr) begin
                resume <= cyc + FC + 1; e_shadow <= 1;
            end else
                e_shadow <= (cyc + 1 < resume);
            cyc <= cyc + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            check("exVld", 64'(exVld), 64'(e_vld));
            check("redirVld", 64'(redirVld), 64'(e_redir));
            check("redirPC", 64'(redirPC), 64'(e_redirpc));
            check("inShadow", 64'(inShadow), 64'(e_shadow));
            check("brCount", 64'(brCount), 64'(e_br));
            check("missCount", 64'(missCount), 64'(e_miss));
            if (e_vld) begin
                check("exPC", 64'(exPC), 64'(e_pc));
                check("exPCTar", 64'(exPCTar), 64'(e_tar));
                check("exType", 64'(exType), 64'(e_type));
                check("exBranch", 64'(exBranch), 64'(e_branch));
                check("exWrong", 64'(exWrong), 64'(e_wrong));
            end
        end
    end

    task automatic step(input logic v, input logic [AW-1:0] pc, input logic [1:0] ty,
                        input logic cd, input logic [AW-1:0] tg, input logic pb,
                        input logic [AW-1:0] pp, input logic fl);
        @(negedge clk);
        brVld = v; brPC = pc; brType = ty; brCond = cd; brTarget = tg;
        pdBranch = pb; pdPC = pp; extFlush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic settle();
        @(posedge clk); #1;
    endtask

    logic [CW-1:0] miss_save;

    initial begin
        #2;
        check("rst_exVld", 64'(exVld), 64'd0);
        check("rst_redirPC", 64'(redirPC), 64'd0);
        check("rst_brCount", 64'(brCount), 64'd0);
        @(negedge clk); rst = 0;

        // correct not-taken conditional
        step(1, 32'h1000, 2'b01, 0, 32'h1100, 0, 32'h1004, 0); settle();
        check("t1_exVld", 64'(exVld), 64'd1);
        check("t1_exWrong", 64'(exWrong), 64'd0);
        check("t1_redirVld", 64'(redirVld), 64'd0);
        check("t1_brCount", 64'(brCount), 64'd1);

        // mispredicted taken, then three shadowed inputs, fourth accepted
        step(1, 32'h2000, 2'b01, 1, 32'h3000, 0, 32'h2004, 0); settle();
        check("t2_redirVld", 64'(redirVld), 64'd1);
        check("t2_redirPC", 64'(redirPC), 64'h3000);
        check("t2_exPCTar", 64'(exPCTar), 64'hC00);
        check("t2_inShadow", 64'(inShadow), 64'd1);
        for (int i = 0; i < FC; i++) begin
            step(1, 32'h5000, 2'b10, 0, 32'h5100, 1, 32'h5100, 0); settle();
            check("t2_shadow_exVld", 64'(exVld), 64'd0);
        end
        step(1, 32'h5000, 2'b10, 0, 32'h5100, 1, 32'h5100, 0); settle();
        check("t2_resume_exVld", 64'(exVld), 64'd1);

        // indirect, right direction, wrong target
        step(1, 32'h4000, 2'b11, 0, 32'h4400, 1, 32'h4000, 0); settle();
        check("t3_exWrong", 64'(exWrong), 64'd1);
        check("t3_redirPC", 64'(redirPC), 64'h4400);
        idle(FC);

        // extFlush beats a simultaneous mispredict
        miss_save = missCount;
        step(1, 32'h6000, 2'b01, 1, 32'h7000, 0, 32'h6004, 1); settle();
        check("t4_redirVld", 64'(redirVld), 64'd0);
        check("t4_exVld", 64'(exVld), 64'd0);
        check("t4_inShadow", 64'(inShadow), 64'd0);
        check("t4_missCount", 64'(missCount), 64'(miss_save));

        // extFlush inside the shadow ends it at once
        step(1, 32'h6000, 2'b01, 1, 32'h7000, 0, 32'h6004, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        step(1, 32'h6100, 2'b10, 0, 32'h6200, 1, 32'h6200, 0); settle();
        check("t4b_exVld", 64'(exVld), 64'd1);

        // PC wrap and a non-branch predicted taken
        step(1, 32'hFFFFFFFC, 2'b01, 0, 32'h10, 0, 32'h0, 0); settle();
        check("t5_wrap_exWrong", 64'(exWrong), 64'd0);
        step(1, 32'h8000, 2'b00, 0, 32'h0, 1, 32'h9000, 0); settle();
        check("t5_none_exWrong", 64'(exWrong), 64'd1);
        check("t5_none_redirPC", 64'(redirPC), 64'h8004);
        idle(FC);

        // drive both counters past saturation
        for (int i = 0; i < 14; i++) begin
            step(1, 32'hA000 + 32'(i * 16), 2'b01, 1, 32'hB000, 0, 32'h0, 0);
            idle(FC);
        end
        settle();
        check("t5_miss_sat", 64'(missCount), 64'hF);
        check("t5_br_sat", 64'(brCount), 64'hF);

        // async reset in the shadow
        step(1, 32'hC000, 2'b10, 0, 32'hD000, 0, 32'hC004, 0); settle();
        check("t6_inShadow", 64'(inShadow), 64'd1);
        #2 rst = 1; #1;
        check("t6_rst_redirVld", 64'(redirVld), 64'd0);
        check("t6_rst_redirPC", 64'(redirPC), 64'd0);
        check("t6_rst_inShadow", 64'(inShadow), 64'd0);
        check("t6_rst_missCount", 64'(missCount), 64'd0);
        @(negedge clk);
        rst = 0;
        brVld = 1; brPC = 32'hE000; brType = 2'b01; brCond = 0; brTarget = 32'hE100;
        pdBranch = 0; pdPC = 32'hE004; extFlush = 0;
        settle();
        check("t6_post_exVld", 64'(exVld), 64'd1);
        check("t6_post_brCount", 64'(brCount), 64'd1);
        idle(2);
        settle();

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
